// File: rtl/dmem_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dmem_pkg : data-memory I/O address map and decode helper              |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package dmem_pkg;

   localparam logic [15:0] c_IO_BASE     = 16'hFF00;
   localparam logic [15:0] c_ADDR_LED    = c_IO_BASE + 16'd0;
   localparam logic [15:0] c_ADDR_SW     = c_IO_BASE + 16'd1;
   localparam logic [15:0] c_ADDR_CNT    = c_IO_BASE + 16'd2;
   localparam logic [15:0] c_ADDR_CMP    = c_IO_BASE + 16'd3;
   localparam logic [15:0] c_ADDR_STATUS = c_IO_BASE + 16'd4;

   typedef enum logic [2:0] {
      SEL_RAM    = 3'd0,
      SEL_LED    = 3'd1,
      SEL_SW     = 3'd2,
      SEL_CNT    = 3'd3,
      SEL_CMP    = 3'd4,
      SEL_STATUS = 3'd5,
      SEL_NONE   = 3'd6
   } dsel_e;

   // RAM occupies every address whose bits above AW are all zero.
   function automatic dsel_e dmem_decode(input logic [15:0] addr, input int unsigned aw);
      dsel_e sel;
      sel = SEL_NONE;
      if ((addr >> aw) == 16'd0) begin
         sel = SEL_RAM;
      end else begin
         case (addr)
            c_ADDR_LED:    sel = SEL_LED;
            c_ADDR_SW:     sel = SEL_SW;
            c_ADDR_CNT:    sel = SEL_CNT;
            c_ADDR_CMP:    sel = SEL_CMP;
            c_ADDR_STATUS: sel = SEL_STATUS;
            default:       sel = SEL_NONE;
         endcase
      end
      return sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dmem_ram : 2^AW x 16 RAM, asynchronous read, synchronous write        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module dmem_ram #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [15:0]   i_wdata,
   output logic [15:0]   o_rdata
);

   logic [15:0] r_mem [2**AW];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/data_mem_io.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | data_mem_io : CPU data memory with LED/switch/counter/compare I/O     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module data_mem_io
   import dmem_pkg::*;
#(
   parameter int AW = 8
) (
   input  logic        CK,
   input  logic        RST,
   input  logic [15:0] DA,
   inout  wire  [15:0] DD,
   input  logic        RW,
   input  logic [15:0] SW,
   output logic [15:0] LED,
   output logic        IRQ
);

   dsel_e       w_sel;
   logic        w_wr;
   logic        w_ram_we;
   logic [15:0] w_ram_rdata;
   logic [15:0] w_rdata;

   logic [15:0] r_led;
   logic [15:0] r_cnt;
   logic [15:0] r_cmp;
   logic        r_status;
   logic [15:0] r_sw_meta;
   logic [15:0] r_sw_sync;

   assign w_sel    = dmem_decode(DA, AW);
   assign w_wr     = !RW;
   assign w_ram_we = w_wr && !RST && (w_sel == SEL_RAM);

   dmem_ram #(
      .AW(AW)
   ) u_ram (
      .clk    (CK),
      .i_we   (w_ram_we),
      .i_addr (DA[AW-1:0]),
      .i_wdata(DD),
      .o_rdata(w_ram_rdata)
   );

   always_ff @(posedge CK) begin
      if (RST) begin
         r_led     <= 16'h0000;
         r_cnt     <= 16'h0000;
         r_cmp     <= 16'hFFFF;
         r_status  <= 1'b0;
         r_sw_meta <= 16'h0000;
         r_sw_sync <= 16'h0000;
      end else begin
         r_sw_meta <= SW;
         r_sw_sync <= r_sw_meta;

         if (w_wr && (w_sel == SEL_LED)) begin
            r_led <= DD;
         end
         if (w_wr && (w_sel == SEL_CMP)) begin
            r_cmp <= DD;
         end
         if (w_wr && (w_sel == SEL_CNT)) begin
            r_cnt <= DD;
         end else begin
            r_cnt <= r_cnt + 16'd1;
         end

         // A match in this cycle beats a concurrent write-1-to-clear.
         if (r_cnt == r_cmp) begin
            r_status <= 1'b1;
         end else if (w_wr && (w_sel == SEL_STATUS) && DD[0]) begin
            r_status <= 1'b0;
         end
      end
   end

   always_comb begin
      w_rdata = 16'h0000;
      case (w_sel)
         SEL_RAM:    w_rdata = w_ram_rdata;
         SEL_LED:    w_rdata = r_led;
         SEL_SW:     w_rdata = r_sw_sync;
         SEL_CNT:    w_rdata = r_cnt;
         SEL_CMP:    w_rdata = r_cmp;
         SEL_STATUS: w_rdata = {15'd0, r_status};
         default:    w_rdata = 16'h0000;
      endcase
   end

   assign DD  = RW ? w_rdata : 16'bz;
   assign LED = r_led;
   assign IRQ = r_status;

endmodule
`default_nettype wire
